// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences accumulator over a window of WIN_PIXELS pixel pairs.
// Optional early abort against a fed-back best sum: define SAD_EARLY_TERM_EN.
module sad_accumulator #(
  parameter int unsigned WIN_PIXELS = 16,
  parameter int unsigned PIX_W      = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             iStart,
  input  logic             iPixValid,
  input  logic [PIX_W-1:0] iPixA,
  input  logic [PIX_W-1:0] iPixB,
  input  logic [31:0]      iBestSum,
  output logic             oPixReady,
  output logic             oBusy,
  output logic [31:0]      oSAD,
  output logic             oSADValid,
  output logic [15:0]      oCount
);

  localparam int unsigned SUM_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DIFF_W = PIX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   sad_q, sad_d;
  logic               sad_valid_q, sad_valid_d;
  logic               pix_ready_q, pix_ready_d;
  logic               busy_q, busy_d;

  logic               accept_c;
  logic [DIFF_W-1:0]  diff_c;
  logic [SUM_W-1:0]   acc_sum_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               last_c;
  logic               abort_c;

  // Per-pair datapath: absolute difference, post-add sum and count.
  always_comb begin
    accept_c  = (state_q == S_ACCUM) && iPixValid;
    if (iPixA >= iPixB) begin
      diff_c = {1'b0, iPixA} - {1'b0, iPixB};
    end else begin
      diff_c = {1'b0, iPixB} - {1'b0, iPixA};
    end
    acc_sum_c = acc_q + SUM_W'(diff_c);
    cnt_inc_c = count_q + CNT_W'(1);
    last_c    = (cnt_inc_c == CNT_W'(WIN_PIXELS));
  end

`ifdef SAD_EARLY_TERM_EN
  // Window is hopeless once its partial sum already exceeds the best so far.
  assign abort_c = (acc_sum_c > iBestSum);
`else
  logic unused_best_sum_c;
  assign abort_c           = 1'b0;
  assign unused_best_sum_c = ^iBestSum;
`endif

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept_c && (last_c || abort_c)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values; status flags follow the next state so they are registered.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    sad_d       = sad_q;
    sad_valid_d = 1'b0;
    pix_ready_d = (state_d == S_ACCUM);
    busy_d      = (state_d != S_IDLE);

    if ((state_q == S_IDLE) && iStart) begin
      acc_d   = '0;
      count_d = '0;
    end

    if (accept_c) begin
      acc_d   = acc_sum_c;
      count_d = cnt_inc_c;
    end

    if ((state_q == S_ACCUM) && (state_d == S_DONE)) begin
      sad_valid_d = 1'b1;
      sad_d       = abort_c ? {SUM_W{1'b1}} : acc_sum_c;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign oPixReady = pix_ready_q;
  assign oBusy     = busy_q;
  assign oSAD      = sad_q;
  assign oSADValid = sad_valid_q;
  assign oCount    = count_q;

endmodule
